alu_ctrl_fsm: RTL
=================

# alu_ctrl_fsm

Multi-cycle control sequencer that drives the ALU's control interface (add_sub, ConstVar, LogicFn, ShiftFn, FnClass). It fetches a 32-bit instruction, decodes it into registered ALU control fields and datapath enables, and sequences execute, memory and write-back. It sits between instruction/data memory handshakes and the register file + ALU datapath, and consumes the ALU's Overflow flag.

## Interface
- MEM_TIMEOUT, 255: max wait cycles for instr_ack/dmem_ack before timeout trap (1..255)
- clk  in  1  rising-edge clock
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- start  in  1  leave IDLE and begin fetching
- instr_req  out  1  instruction fetch request
- instr_ack  in  1  instruction valid on instr_in
- instr_in  in  32  instruction word
- ir_we  out  1  load instruction register
- dmem_req  out  1  data memory request
- dmem_we  out  1  1 = store, 0 = load (valid with dmem_req)
- dmem_ack  in  1  data access complete
- add_sub, ConstVar  out  1 each  ALU controls
- LogicFn, ShiftFn  out  2 each  ALU controls
- FnClass  out  3  ALU result select
- alu_src_imm  out  1  ALU y = sign-extended imm16
- reg_we  out  1  register-file write strobe
- wb_sel  out  1  0 = ALU result, 1 = memory data
- pc_en  out  1  PC += 4 strobe
- Overflow  in  1  ALU overflow flag
- busy, halted, trap  out  1 each  status
- trap_cause  out  2  01 illegal, 10 overflow, 11 timeout

## Operation
- Encoding: opcode = instr[31:26]; R-type 6'h00, funct = instr[3:0]; I-type 6'h10..6'h1F, funct = opcode[3:0]; 6'h20 LD, 6'h21 ST, 6'h3F HALT; all else illegal.
- funct: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SLL, 7 SRL, 8 SRA, 9 SLT, A SGT, B HAM, C LUI (I-type only), D-F illegal.
- FnClass: 000 arith, 001 logic, 010 shift, 011 slt, 100 sgt, 101 lui, 110 ham. LogicFn: 00 AND, 01 OR, 10 XOR, 11 NOR. ShiftFn: 00 SLL, 01 SRL, 10 SRA.
- add_sub = 1 for SUB, SLT, SGT; else 0. ConstVar = 1 for I-type shifts; 0 otherwise. alu_src_imm = 1 for I-type, LD, ST.
- LD/ST: FnClass 000, add_sub 0, alu_src_imm 1 (address = rs + imm).
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT, TRAP.
- IDLE -> FETCH on start. FETCH -> DECODE on instr_ack. DECODE -> TRAP on illegal; -> HALT on 6'h3F; else -> EXEC. EXEC -> MEM for LD/ST; else -> WB. MEM -> WB on dmem_ack for LD; -> FETCH on dmem_ack for ST, with pc_en pulse. WB -> FETCH.
- HALT and TRAP are sticky until reset; start ignored there.
- Wait counter (8 bit): cleared on FETCH/MEM entry, increments each cycle without ack; reaching MEM_TIMEOUT -> TRAP, cause 11.

## Timing
- Reset: state IDLE; every output 0, including all ALU controls, trap_cause 00.
- instr_req held high throughout FETCH; ir_we pulses for 1 cycle in the cycle instr_ack is sampled high.
- ALU controls registered at DECODE exit; stable from EXEC through WB/MEM; cleared to 0 on FETCH entry.
- Overflow sampled at end of EXEC.
- dmem_req, dmem_we held for the whole of MEM.
- reg_we and pc_en: 1-cycle pulses in WB. No reg_we for ST, HALT or trap.
- Latency with ack on first request cycle: ALU op 4 cycles, LD 5, ST 4 (start of FETCH to next FETCH).
- busy = 1 in FETCH..WB; halted = 1 in HALT; trap = 1 in TRAP.
- Ack arriving when no request is outstanding is ignored.
- Asynchronous reset mid-operation: immediate return to IDLE; outputs clear without waiting for a clock edge.

## Configuration
- ALU_OVF_TRAP_EN defined: Overflow = 1 at end of EXEC for ADD/SUB (R- or I-type) -> TRAP, cause 10, no reg_we, no pc_en.
- ALU_OVF_TRAP_EN undefined: Overflow is ignored and the result is written back normally.

## Test plan
- R-type SUB (opcode 00, funct 1), instr_ack on first cycle -> EXEC shows add_sub = 1, FnClass 000; reg_we pulses 3 cycles after ack; next instr_req at cycle 4.
- I-type SRA (opcode 6'h18) -> ConstVar = 1, ShiftFn 10, FnClass 010, alu_src_imm = 1.
- LD with dmem_ack delayed 3 cycles -> dmem_req high 4 cycles, dmem_we = 0; WB has wb_sel = 1 and reg_we pulse. Illegal opcode 6'h05 -> trap = 1, cause 01, no reg_we.
- instr_ack withheld, MEM_TIMEOUT = 4 -> TRAP, cause 11, after 4 waiting cycles; start is then ignored.
- Overflow = 1 on ADD: with ALU_OVF_TRAP_EN -> TRAP, cause 10, no reg_we; without it -> normal WB with reg_we pulse.
- rst_n asserted in MEM -> outputs 0 immediately; after release, state IDLE until start.

Source files
------------

// File: rtl/alu_ctrl_fsm.sv
// alu_ctrl_fsm - multi-cycle control sequencer for the ALU datapath.
//
// Fetches a 32-bit instruction, decodes it into registered ALU control
// fields, then sequences execute, memory access and write-back.
// Optional feature macro: ALU_OVF_TRAP_EN (trap on ADD/SUB overflow).
//
// Ports:
//   clk_i, rst_n              clock, asynchronous active-low reset
//   start_i                   leave IDLE and begin fetching
//   instr_req_o/instr_ack_i   instruction fetch handshake, instr_in_i word
//   ir_we_o                   load external instruction register
//   dmem_req_o/dmem_we_o      data memory request, 1 = store
//   dmem_ack_i                data access complete
//   add_sub_o, ConstVar_o, LogicFn_o, ShiftFn_o, FnClass_o   ALU controls
//   alu_src_imm_o             ALU y operand = sign-extended imm16
//   reg_we_o, wb_sel_o        register-file write strobe / source select
//   pc_en_o                   PC += 4 strobe
//   Overflow_i                ALU overflow flag
//   busy_o, halted_o, trap_o  status; trap_cause_o 01 illegal, 10 ovf, 11 timeout
module alu_ctrl_fsm #(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        rst_n,
    input  logic        start_i,
    output logic        instr_req_o,
    input  logic        instr_ack_i,
    input  logic [31:0] instr_in_i,
    output logic        ir_we_o,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    input  logic        dmem_ack_i,
    output logic        add_sub_o,
    output logic        ConstVar_o,
    output logic [1:0]  LogicFn_o,
    output logic [1:0]  ShiftFn_o,
    output logic [2:0]  FnClass_o,
    output logic        alu_src_imm_o,
    output logic        reg_we_o,
    output logic        wb_sel_o,
    output logic        pc_en_o,
    input  logic        Overflow_i,
    output logic        busy_o,
    output logic        halted_o,
    output logic        trap_o,
    output logic [1:0]  trap_cause_o
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6,
        S_TRAP   = 3'd7
    } state_t;

    typedef struct packed {
        logic       add_sub;
        logic       const_var;
        logic [1:0] logic_fn;
        logic [1:0] shift_fn;
        logic [2:0] fn_class;
        logic       src_imm;
        logic       is_ld;
        logic       is_st;
        logic       ovf_chk;   // ADD/SUB: subject to overflow trap
    } ctrl_t;

    typedef struct packed {
        logic  legal;
        logic  halt;
        ctrl_t c;
    } dec_t;

`ifdef ALU_OVF_TRAP_EN
    localparam logic OVF_TRAP = 1'b1;
`else
    localparam logic OVF_TRAP = 1'b0;
`endif
    // Counter value on the last permitted wait cycle.
    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    // Instruction decode; an all-zero result means illegal.
    function automatic dec_t decode_f(input logic [5:0] op, input logic [3:0] rfn);
        dec_t       d;
        logic       itype;
        logic [3:0] fn;
        d     = '0;
        itype = (op[5:4] == 2'b01);
        fn    = itype ? op[3:0] : rfn;
        if (op == 6'h3F) begin
            d.legal = 1'b1;
            d.halt  = 1'b1;
        end else if ((op == 6'h20) || (op == 6'h21)) begin
            d.legal     = 1'b1;
            d.c.src_imm = 1'b1;
            d.c.is_ld   = ~op[0];
            d.c.is_st   = op[0];
        end else if ((op == 6'h00) || itype) begin
            d.legal     = 1'b1;
            d.c.src_imm = itype;
            case (fn)
                4'h0: d.c.ovf_chk = 1'b1;
                4'h1: begin
                    d.c.add_sub = 1'b1;
                    d.c.ovf_chk = 1'b1;
                end
                // funct 2..5 map onto LogicFn 0..3 by adding 2 modulo 4
                4'h2, 4'h3, 4'h4, 4'h5: begin
                    d.c.fn_class = 3'b001;
                    d.c.logic_fn = fn[1:0] + 2'd2;
                end
                // funct 6..8 map onto ShiftFn 0..2 by the same offset
                4'h6, 4'h7, 4'h8: begin
                    d.c.fn_class  = 3'b010;
                    d.c.shift_fn  = fn[1:0] + 2'd2;
                    d.c.const_var = itype;
                end
                4'h9: begin
                    d.c.fn_class = 3'b011;
                    d.c.add_sub  = 1'b1;
                end
                4'hA: begin
                    d.c.fn_class = 3'b100;
                    d.c.add_sub  = 1'b1;
                end
                4'hB: d.c.fn_class = 3'b110;
                4'hC: begin
                    if (itype) begin
                        d.c.fn_class = 3'b101;
                    end else begin
                        d = '0;
                    end
                end
                default: d = '0;
            endcase
        end else begin
            d = '0;
        end
        return d;
    endfunction

    state_t      state_q, state_d;
    logic [7:0]  wait_q, wait_d;
    logic [1:0]  cause_q, cause_d;
    ctrl_t       ctrl_q, ctrl_d;
    logic [9:0]  ir_q, ir_d;   // opcode + R-type funct: all decode needs
    dec_t        dec_s;

    // State and datapath-control registers.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            wait_q  <= 8'd0;
            cause_q <= 2'b00;
            ctrl_q  <= '0;
            ir_q    <= 10'd0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            cause_q <= cause_d;
            ctrl_q  <= ctrl_d;
            ir_q    <= ir_d;
        end
    end

    // Next-state, wait counter, trap cause and control-field update.
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        cause_d = cause_q;
        ctrl_d  = ctrl_q;
        ir_d    = ir_q;
        dec_s   = decode_f(ir_q[9:4], ir_q[3:0]);
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_FETCH;
                    wait_d  = 8'd0;
                    ctrl_d  = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FETCH: begin
                if (instr_ack_i) begin
                    ir_d    = {instr_in_i[31:26], instr_in_i[3:0]};
                    state_d = S_DECODE;
                end else if (wait_q == WAIT_LAST) begin
                    state_d = S_TRAP;
                    cause_d = 2'b11;
                    ctrl_d  = '0;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            S_DECODE: begin
                if (!dec_s.legal) begin
                    state_d = S_TRAP;
                    cause_d = 2'b01;
                end else if (dec_s.halt) begin
                    state_d = S_HALT;
                end else begin
                    state_d = S_EXEC;
                    ctrl_d  = dec_s.c;
                end
            end
            S_EXEC: begin
                if (OVF_TRAP && ctrl_q.ovf_chk && Overflow_i) begin
                    state_d = S_TRAP;
                    cause_d = 2'b10;
                    ctrl_d  = '0;
                end else if (ctrl_q.is_ld || ctrl_q.is_st) begin
                    state_d = S_MEM;
                    wait_d  = 8'd0;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                if (dmem_ack_i) begin
                    if (ctrl_q.is_st) begin
                        state_d = S_FETCH;
                        wait_d  = 8'd0;
                        ctrl_d  = '0;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (wait_q == WAIT_LAST) begin
                    state_d = S_TRAP;
                    cause_d = 2'b11;
                    ctrl_d  = '0;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            S_WB: begin
                state_d = S_FETCH;
                wait_d  = 8'd0;
                ctrl_d  = '0;
            end
            S_HALT:  state_d = S_HALT;
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_IDLE;
        endcase
    end

    // Handshake strobes and status decoded from the current state.
    always_comb begin
        instr_req_o = 1'b0;
        ir_we_o     = 1'b0;
        dmem_req_o  = 1'b0;
        dmem_we_o   = 1'b0;
        reg_we_o    = 1'b0;
        pc_en_o     = 1'b0;
        busy_o      = 1'b0;
        halted_o    = 1'b0;
        trap_o      = 1'b0;
        case (state_q)
            S_FETCH: begin
                instr_req_o = 1'b1;
                ir_we_o     = instr_ack_i;
                busy_o      = 1'b1;
            end
            S_DECODE: busy_o = 1'b1;
            S_EXEC:   busy_o = 1'b1;
            S_MEM: begin
                busy_o     = 1'b1;
                dmem_req_o = 1'b1;
                dmem_we_o  = ctrl_q.is_st;
                // a store retires here, so its PC step comes with the ack
                pc_en_o    = dmem_ack_i & ctrl_q.is_st;
            end
            S_WB: begin
                busy_o   = 1'b1;
                reg_we_o = 1'b1;
                pc_en_o  = 1'b1;
            end
            S_HALT:  halted_o = 1'b1;
            S_TRAP:  trap_o   = 1'b1;
            default: busy_o   = 1'b0;
        endcase
    end

    assign add_sub_o     = ctrl_q.add_sub;
    assign ConstVar_o    = ctrl_q.const_var;
    assign LogicFn_o     = ctrl_q.logic_fn;
    assign ShiftFn_o     = ctrl_q.shift_fn;
    assign FnClass_o     = ctrl_q.fn_class;
    assign alu_src_imm_o = ctrl_q.src_imm;
    assign wb_sel_o      = ctrl_q.is_ld;
    assign trap_cause_o  = cause_q;

endmodule
